pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Instruction-cycle controller for the PIC16F core program counter. Decodes the instruction
//  in execute and drives the program counter's increment, jump, push, pop and ISR-entry strobes.
//  Inserts the flush cycle after taken branches, skips, RETURN/RETLW/RETFIE and PCL writes.
//  Sequences interrupt entry and GIE clear/set. Sits between instruction register/ALU and PC.
// PARAMETERS
//  ISR_VECTOR  13'h0004  documentation only; PC hard-codes the ISR vector, no port carries it
// PORTS
//  clk              in   1   clock
//  rst              in   1   reset, synchronous, active-high
//  instr            in   14  instruction fetched last cycle (valid in EXEC)
//  skip_cond        in   1   ALU: BTFSC/BTFSS/DECFSZ/INCFSZ skip condition true this cycle
//  pcl_write        in   1   datapath writes PCL this cycle (PC takes pclath:pcl_in)
//  irq_pending      in   1   any enabled interrupt flag set
//  gie              in   1   INTCON.GIE
//  pc_incr_en       out  1   PC <= PC+1
//  pc_j_en          out  1   GOTO: PC <= {pclath[4:3], pc_j_addr}
//  pc_j_and_push_en out  1   CALL: push PC, then jump
//  pc_j_by_pop_en   out  1   RETURN/RETLW/RETFIE: PC <= top of stack
//  pc_j_to_isr      out  1   push PC, PC <= 0x0004
//  pc_j_addr        out  11  instr[10:0], always driven
//  exec_en          out  1   instr is architecturally executed this cycle (else NOP)
//  gie_clr          out  1   clear GIE (ISR entry)
//  gie_set          out  1   set GIE (RETFIE)
//  state            out  2   current FSM state, for debug/bench
// BEHAVIOUR
//  Strobes are combinational from registered state + instr/skip_cond/pcl_write/irq inputs.
//  At most one of pc_incr_en/pc_j_en/pc_j_and_push_en/pc_j_by_pop_en/pc_j_to_isr is high.
//  States: FETCH0=0, EXEC=1, FLUSH=2, SLEEP=3. Reset -> FETCH0; all strobes 0 during rst.
//  FETCH0: pc_incr_en=1, exec_en=0 (load instr from addr 0); -> EXEC.
//  EXEC, exec_en=1, decode priority:
//   GOTO  instr[13:11]=3'b101 -> pc_j_en, -> FLUSH
//   CALL  instr[13:11]=3'b100 -> pc_j_and_push_en, -> FLUSH
//   RETURN 14'h0008, RETLW instr[13:10]=4'b1101 -> pc_j_by_pop_en, -> FLUSH
//   RETFIE 14'h0009 -> pc_j_by_pop_en + gie_set, -> FLUSH
//   skip-class (BTFSC 0110, BTFSS 0111, DECFSZ 001011, INCFSZ 001111) with skip_cond=1
//     -> pc_incr_en, -> FLUSH (next fetched word discarded)
//   pcl_write=1 -> no PC strobe (PC loads itself), -> FLUSH
//   otherwise: if irq_pending & gie -> pc_j_to_isr + gie_clr, -> FLUSH (instr still
//     executes; pushed PC = following address); else pc_incr_en, stay EXEC
//  FLUSH: exec_en=0, pc_incr_en=1 (fetch word at new PC); -> EXEC. No irq taken in FLUSH;
//   pending irq is taken at next non-redirecting EXEC.
//  Skip/branch instr with skip_cond low behaves as ordinary instr (irq may be taken).
//  Redirecting instr (branch, taken skip, pcl_write) defers irq one instruction.
//  skip_cond/pcl_write ignored outside EXEC. rst mid-operation -> FETCH0 next cycle.
//  Branch/skip cost 2 cycles; all others 1 cycle.
// CONFIGURATION
//  PC_SEQ_SLEEP_EN defined: SLEEP (14'h0063) in EXEC -> no PC strobe, -> SLEEP state;
//   SLEEP: all strobes 0, exec_en=0; irq_pending=1 -> EXEC (resumes at instr after SLEEP;
//   if gie=1 that EXEC takes ISR normally). state=3 reachable.
//  Not defined: SLEEP is an ordinary instr (pc_incr_en); state 3 unreachable.
// TESTING
//  rst 3 cycles, release -> FETCH0 one cycle (pc_incr_en=1, exec_en=0), then EXEC.
//  instr=14'h2805 (GOTO 5) in EXEC -> pc_j_en=1, pc_j_addr=11'h005; next cycle FLUSH exec_en=0.
//  instr=14'h2010 (CALL 0x10) then 14'h0008 -> push/jump+FLUSH, pop+FLUSH; 4 cycles total.
//  instr=14'h1903 (BTFSC), skip_cond=1 -> pc_incr_en then FLUSH; skip_cond=0 -> stay EXEC.
//  irq_pending=1,gie=1 during GOTO -> pc_j_en, FLUSH, then ordinary instr gets pc_j_to_isr+gie_clr.
//  PC_SEQ_SLEEP_EN: instr=14'h0063 -> SLEEP, strobes 0 for 10 cycles; irq_pending=1 -> EXEC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-cycle controller for the PIC16F program counter.
// Decodes the executing instruction and drives the PC increment/jump/push/pop/ISR strobes,
// inserting a flush cycle after every redirect and sequencing interrupt entry.
// Optional feature macro: PC_SEQ_SLEEP_EN (SLEEP instruction parks the core until an irq).
module pc_sequencer #(
  // The PC hard-codes the ISR vector; this value is documentation only.
  parameter logic [12:0] ISR_VECTOR = 13'h0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] i_instr,
  input  logic        i_skip_cond,
  input  logic        i_pcl_write,
  input  logic        i_irq_pending,
  input  logic        i_gie,
  output logic        o_pc_incr_en,
  output logic        o_pc_j_en,
  output logic        o_pc_j_and_push_en,
  output logic        o_pc_j_by_pop_en,
  output logic        o_pc_j_to_isr,
  output logic [10:0] o_pc_j_addr,
  output logic        o_exec_en,
  output logic        o_gie_clr,
  output logic        o_gie_set,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    StFetch0 = 2'd0,
    StExec   = 2'd1,
    StFlush  = 2'd2,
    StSleep  = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Only the default vector is wired into the PC; other values have no effect.
  if (ISR_VECTOR != 13'h0004) begin : g_nonstd_isr_vector
  end

  // Instruction class decode.
  logic w_is_goto;
  logic w_is_call;
  logic w_is_return;
  logic w_is_retfie;
  logic w_is_skip_class;
  logic w_skip_taken;

  assign w_is_goto       = (i_instr[13:11] == 3'b101);
  assign w_is_call       = (i_instr[13:11] == 3'b100);
  assign w_is_return     = (i_instr == 14'h0008) || (i_instr[13:10] == 4'b1101);
  assign w_is_retfie     = (i_instr == 14'h0009);
  assign w_is_skip_class = (i_instr[13:10] == 4'b0110) || (i_instr[13:10] == 4'b0111) ||
                           (i_instr[13:8] == 6'b001011) || (i_instr[13:8] == 6'b001111);
  assign w_skip_taken    = w_is_skip_class && i_skip_cond;

`ifdef PC_SEQ_SLEEP_EN
  logic w_is_sleep;
  assign w_is_sleep = (i_instr == 14'h0063);
`endif

  assign o_pc_j_addr = i_instr[10:0];
  assign o_state     = r_state;

  // State register; synchronous reset returns to the first fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFetch0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobe decode; everything held low while rst is asserted.
  always_comb begin
    w_state_next       = r_state;
    o_pc_incr_en       = 1'b0;
    o_pc_j_en          = 1'b0;
    o_pc_j_and_push_en = 1'b0;
    o_pc_j_by_pop_en   = 1'b0;
    o_pc_j_to_isr      = 1'b0;
    o_exec_en          = 1'b0;
    o_gie_clr          = 1'b0;
    o_gie_set          = 1'b0;
    if (!rst) begin
      case (r_state)
        StFetch0: begin
          o_pc_incr_en = 1'b1;
          w_state_next = StExec;
        end
        StExec: begin
          o_exec_en = 1'b1;
          if (w_is_goto) begin
            o_pc_j_en    = 1'b1;
            w_state_next = StFlush;
          end else if (w_is_call) begin
            o_pc_j_and_push_en = 1'b1;
            w_state_next       = StFlush;
          end else if (w_is_return) begin
            o_pc_j_by_pop_en = 1'b1;
            w_state_next     = StFlush;
          end else if (w_is_retfie) begin
            o_pc_j_by_pop_en = 1'b1;
            o_gie_set        = 1'b1;
            w_state_next     = StFlush;
          end else if (w_skip_taken) begin
            // Increment past the prefetched word, which the flush then discards.
            o_pc_incr_en = 1'b1;
            w_state_next = StFlush;
          end else if (i_pcl_write) begin
            // PC loads pclath:pcl itself; only the flush is needed here.
            w_state_next = StFlush;
`ifdef PC_SEQ_SLEEP_EN
          end else if (w_is_sleep) begin
            w_state_next = StSleep;
`endif
          end else if (i_irq_pending && i_gie) begin
            // The current instruction still executes; the pushed PC is the next address.
            o_pc_j_to_isr = 1'b1;
            o_gie_clr     = 1'b1;
            w_state_next  = StFlush;
          end else begin
            o_pc_incr_en = 1'b1;
            w_state_next = StExec;
          end
        end
        StFlush: begin
          o_pc_incr_en = 1'b1;
          w_state_next = StExec;
        end
        StSleep: begin
`ifdef PC_SEQ_SLEEP_EN
          if (i_irq_pending) begin
            w_state_next = StExec;
          end
`else
          w_state_next = StFetch0;
`endif
        end
        default: w_state_next = StFetch0;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized
// instruction streams, all compared against a behavioural reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] i_instr;
  logic        i_skip_cond;
  logic        i_pcl_write;
  logic        i_irq_pending;
  logic        i_gie;
  logic        o_pc_incr_en;
  logic        o_pc_j_en;
  logic        o_pc_j_and_push_en;
  logic        o_pc_j_by_pop_en;
  logic        o_pc_j_to_isr;
  logic [10:0] o_pc_j_addr;
  logic        o_exec_en;
  logic        o_gie_clr;
  logic        o_gie_set;
  logic [1:0]  o_state;

  pc_sequencer u_dut (
    .clk                (clk),
    .rst                (rst),
    .i_instr            (i_instr),
    .i_skip_cond        (i_skip_cond),
    .i_pcl_write        (i_pcl_write),
    .i_irq_pending      (i_irq_pending),
    .i_gie              (i_gie),
    .o_pc_incr_en       (o_pc_incr_en),
    .o_pc_j_en          (o_pc_j_en),
    .o_pc_j_and_push_en (o_pc_j_and_push_en),
    .o_pc_j_by_pop_en   (o_pc_j_by_pop_en),
    .o_pc_j_to_isr      (o_pc_j_to_isr),
    .o_pc_j_addr        (o_pc_j_addr),
    .o_exec_en          (o_exec_en),
    .o_gie_clr          (o_gie_clr),
    .o_gie_set          (o_gie_set),
    .o_state            (o_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_state  = 0;   // model's current cycle kind: 0 fetch0, 1 exec, 2 flush, 3 sleep
  int m_next   = 0;
  bit m_known  = 1'b0;

  // Strobe vector order: {incr, jump, call, pop, isr, exec, gie_clr, gie_set}.
  localparam int INCR = 7, JMP = 6, CALL = 5, POP = 4, ISR = 3, EXE = 2, GCLR = 1, GSET = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the cycle should do, from the instruction-class rules.
  function automatic void model(input int st, input logic [13:0] ins, input bit sk, input bit pw,
                                input bit irq, input bit g, input bit r,
                                output logic [7:0] exp, output int nst);
    int op;
    op  = int'(ins);
    exp = '0;
    nst = st;
    if (r) begin
      nst = 0;
    end else if (st == 0 || st == 2) begin
      exp[INCR] = 1'b1;
      nst = 1;
    end else if (st == 3) begin
      nst = irq ? 1 : 3;
    end else begin
      exp[EXE] = 1'b1;
      nst = 2;
      if (op / 2048 == 5) exp[JMP] = 1'b1;
      else if (op / 2048 == 4) exp[CALL] = 1'b1;
      else if (op == 8 || op / 1024 == 13) exp[POP] = 1'b1;
      else if (op == 9) begin
        exp[POP] = 1'b1;
        exp[GSET] = 1'b1;
      end else if (sk && (op / 1024 == 6 || op / 1024 == 7 || op / 256 == 11 || op / 256 == 15))
        exp[INCR] = 1'b1;
      else if (pw) nst = 2;
`ifdef PC_SEQ_SLEEP_EN
      else if (op == 99) nst = 3;
`endif
      else if (irq && g) begin
        exp[ISR] = 1'b1;
        exp[GCLR] = 1'b1;
      end else begin
        exp[INCR] = 1'b1;
        nst = 1;
      end
    end
  endfunction

  // One clock cycle: advance the model, drive inputs at negedge, check outputs 1ns later.
  task automatic cyc(input logic [13:0] ins, input bit sk, input bit pw, input bit irq,
                     input bit g, input bit r, input string tag);
    logic [7:0] exp;
    logic [7:0] obs;
    int nst;
    @(posedge clk);
    m_state = m_next;
    @(negedge clk);
    rst = r; i_instr = ins; i_skip_cond = sk; i_pcl_write = pw; i_irq_pending = irq; i_gie = g;
    #1;
    model(m_state, ins, sk, pw, irq, g, r, exp, nst);
    obs = {o_pc_incr_en, o_pc_j_en, o_pc_j_and_push_en, o_pc_j_by_pop_en, o_pc_j_to_isr,
           o_exec_en, o_gie_clr, o_gie_set};
    chk({tag, "_strobes"}, 32'(obs), 32'(exp));
    chk({tag, "_jaddr"}, 32'(o_pc_j_addr), 32'(ins % 2048));
    chk({tag, "_onehot"}, 32'($countones(obs[7:3]) <= 1), 32'd1);
    if (m_known) chk({tag, "_state"}, 32'(o_state), 32'(m_state));
    m_next = nst;
    if (r) m_known = 1'b1;
  endtask

  function automatic logic [13:0] rand_instr();
    logic [13:0] v;
    v = 14'($urandom);
    case ($urandom_range(0, 11))
      0:  return 14'h2800 | (v & 14'h07ff);   // GOTO
      1:  return 14'h2000 | (v & 14'h07ff);   // CALL
      2:  return 14'h0008;                    // RETURN
      3:  return 14'h3400 | (v & 14'h03ff);   // RETLW
      4:  return 14'h0009;                    // RETFIE
      5:  return 14'h1800 | (v & 14'h03ff);   // BTFSC
      6:  return 14'h1c00 | (v & 14'h03ff);   // BTFSS
      7:  return 14'h0b00 | (v & 14'h00ff);   // DECFSZ
      8:  return 14'h0f00 | (v & 14'h00ff);   // INCFSZ
      9:  return 14'h0063;                    // SLEEP
      default: return v;
    endcase
  endfunction

  initial begin
    rst = 1'b1; i_instr = '0; i_skip_cond = 1'b0; i_pcl_write = 1'b0;
    i_irq_pending = 1'b0; i_gie = 1'b0;

    // Reset held three cycles, then one fetch0 cycle.
    for (int i = 0; i < 3; i++) cyc(14'h0000, 1, 1, 1, 1, 1, "rst");
    cyc(14'h0000, 0, 0, 0, 0, 0, "fetch0");
    chk("fetch0_incr", 32'(o_pc_incr_en), 32'd1);
    chk("fetch0_exec", 32'(o_exec_en), 32'd0);
    chk("fetch0_state", 32'(o_state), 32'd0);

    // GOTO 5 and its flush.
    cyc(14'h2805, 0, 0, 0, 0, 0, "goto");
    chk("goto_jen", 32'(o_pc_j_en), 32'd1);
    chk("goto_addr", 32'(o_pc_j_addr), 32'h005);
    cyc(14'h0000, 0, 0, 0, 0, 0, "goto_flush");
    chk("goto_flush_exec", 32'(o_exec_en), 32'd0);
    chk("goto_flush_state", 32'(o_state), 32'd2);

    // CALL 0x10, flush, RETURN, flush.
    cyc(14'h2010, 0, 0, 0, 0, 0, "call");
    chk("call_push", 32'(o_pc_j_and_push_en), 32'd1);
    cyc(14'h0000, 0, 0, 0, 0, 0, "call_flush");
    cyc(14'h0008, 0, 0, 0, 0, 0, "return");
    chk("return_pop", 32'(o_pc_j_by_pop_en), 32'd1);
    cyc(14'h0000, 0, 0, 0, 0, 0, "return_flush");
    chk("return_flush_state", 32'(o_state), 32'd2);

    // BTFSC taken then not taken.
    cyc(14'h1903, 1, 0, 0, 0, 0, "btfsc_taken");
    chk("btfsc_taken_incr", 32'(o_pc_incr_en), 32'd1);
    cyc(14'h0000, 0, 0, 0, 0, 0, "btfsc_flush");
    chk("btfsc_flush_state", 32'(o_state), 32'd2);
    cyc(14'h1903, 0, 0, 0, 0, 0, "btfsc_nt");
    cyc(14'h0000, 0, 0, 0, 0, 0, "btfsc_nt_next");
    chk("btfsc_nt_state", 32'(o_state), 32'd1);

    // Interrupt pending during GOTO is deferred past the flush.
    cyc(14'h2805, 0, 0, 1, 1, 0, "irq_goto");
    chk("irq_goto_no_isr", 32'(o_pc_j_to_isr), 32'd0);
    cyc(14'h0000, 0, 0, 1, 1, 0, "irq_flush");
    chk("irq_flush_no_isr", 32'(o_pc_j_to_isr), 32'd0);
    cyc(14'h0100, 0, 0, 1, 1, 0, "irq_take");
    chk("irq_take_isr", 32'(o_pc_j_to_isr), 32'd1);
    chk("irq_take_gclr", 32'(o_gie_clr), 32'd1);
    cyc(14'h0000, 0, 0, 1, 0, 0, "irq_take_flush");

    // RETFIE and PCL write.
    cyc(14'h0009, 0, 0, 0, 0, 0, "retfie");
    chk("retfie_gset", 32'(o_gie_set), 32'd1);
    cyc(14'h0000, 0, 0, 0, 0, 0, "retfie_flush");
    cyc(14'h0082, 0, 1, 1, 1, 0, "pclw");
    chk("pclw_incr", 32'(o_pc_incr_en), 32'd0);
    cyc(14'h0000, 0, 0, 0, 0, 0, "pclw_flush");

`ifdef PC_SEQ_SLEEP_EN
    cyc(14'h0063, 0, 0, 0, 0, 0, "sleep");
    for (int i = 0; i < 10; i++) cyc(14'h0000, 0, 0, 0, 0, 0, "sleeping");
    chk("sleep_state", 32'(o_state), 32'd3);
    cyc(14'h0000, 0, 0, 1, 0, 0, "wake");
    cyc(14'h0000, 0, 0, 0, 0, 0, "woken");
    chk("wake_state", 32'(o_state), 32'd1);
`else
    cyc(14'h0063, 0, 0, 0, 0, 0, "sleep_nop");
    chk("sleep_nop_incr", 32'(o_pc_incr_en), 32'd1);
`endif

    // Mid-operation reset.
    cyc(14'h2805, 0, 0, 0, 0, 1, "mid_rst");
    cyc(14'h0000, 0, 0, 0, 0, 0, "mid_rst_fetch0");
    chk("mid_rst_state", 32'(o_state), 32'd0);

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      cyc(rand_instr(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
          "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
